// File: rtl/mux2_1_pkg.sv
// Shared constants for the registered 2:1 mux family: core-style codes,
// the width ceiling, and a helper that maps unknown style codes onto the
// behavioural core.
package mux2_1_pkg;

    localparam int STYLE_BEH  = 0;
    localparam int STYLE_DF   = 1;
    localparam int STYLE_GATE = 2;

    localparam int MAX_WIDTH  = 64;

    // Any style code outside the known set builds the behavioural core.
    function automatic int resolveStyle(input int style);
        if (style == STYLE_DF || style == STYLE_GATE) begin
            return style;
        end
        return STYLE_BEH;
    endfunction

endpackage

// File: rtl/mux2_1_gate_bit.sv
// One-bit 2:1 mux built only from NOT, AND and OR primitives:
// y = (a & ~s) | (b & s). Replicated once per bit by the gate core.
module mux2_1_gate_bit (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    wire sN;
    wire aTerm;
    wire bTerm;
    wire orOut;

    not uNot  (sN, s);
    and uAndA (aTerm, a, sN);
    and uAndB (bTerm, b, s);
    or  uOr   (orOut, aTerm, bTerm);

    assign y = orOut;

endmodule

// File: rtl/mux2_1_reg.sv
// Registered 2:1 multiplexer, WIDTH bits (1..MAX_WIDTH), one cycle latency.
// STYLE picks the combinational core feeding the register:
//   0 = behavioural, 1 = dataflow, 2 = gate-level, other = behavioural.
// Build option MUX2_1_REG_XCHECK_EN: all three cores are built and compared
// on every valid cycle; any disagreement sets the sticky mismatch flag.
// Without it only the selected core is built and mismatch is tied low.
//
// Handshake: in_valid qualifies d0/d1/sel at the rising edge where it is
// high. There is no ready; every valid input is accepted. out_valid is high
// for exactly the cycle after each accepted input; out holds its last value
// (with out_valid low) while no input is offered.
module mux2_1_reg
    import mux2_1_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int STYLE = STYLE_BEH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             mismatch
);

    localparam int ACTIVE_STYLE = resolveStyle(STYLE);

`ifdef MUX2_1_REG_XCHECK_EN
    localparam bit BUILD_ALL = 1'b1;
`else
    localparam bit BUILD_ALL = 1'b0;
`endif

    // Per-core results; cores that are not built are tied to zero.
    logic [WIDTH-1:0] behVec;
    logic [WIDTH-1:0] dfVec;
    logic [WIDTH-1:0] gateVec;
    logic [WIDTH-1:0] muxOut;

    generate
        if (BUILD_ALL || ACTIVE_STYLE == STYLE_BEH) begin : gBehCore
            // Behavioural core; an unknown sel falls to d0 in simulation.
            always_comb begin
                behVec = d0;
                case (sel)
                    1'b0:    behVec = d0;
                    1'b1:    behVec = d1;
                    default: behVec = d0;
                endcase
            end
        end else begin : gBehOff
            assign behVec = '0;
        end

        if (BUILD_ALL || ACTIVE_STYLE == STYLE_DF) begin : gDfCore
            assign dfVec = sel ? d1 : d0;
        end else begin : gDfOff
            assign dfVec = '0;
        end

        if (BUILD_ALL || ACTIVE_STYLE == STYLE_GATE) begin : gGateCore
            for (genvar i = 0; i < WIDTH; i++) begin : gGateBit
                mux2_1_gate_bit uBit (
                    .a (d0[i]),
                    .b (d1[i]),
                    .s (sel),
                    .y (gateVec[i])
                );
            end
        end else begin : gGateOff
            assign gateVec = '0;
        end
    endgenerate

    // STYLE is a constant, so this collapses to a wire from one core.
    assign muxOut = (ACTIVE_STYLE == STYLE_DF)   ? dfVec   :
                    (ACTIVE_STYLE == STYLE_GATE) ? gateVec :
                                                   behVec;

    // Output register: capture on valid, hold data and drop valid otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= muxOut;
            end
        end
    end

`ifdef MUX2_1_REG_XCHECK_EN
    logic coresDiffer;

    assign coresDiffer = (behVec != dfVec) || (behVec != gateVec);

    // Sticky cross-check flag: set by any core disagreement on a valid edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch <= 1'b0;
        end else if (in_valid && coresDiffer) begin
            mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_mux2_1_reg.sv
// Directed bench for mux2_1_reg: WIDTH=1 truth table on every style, WIDTH=8
// select/hold/reset sequences on every style, WIDTH=4 traffic against a
// reference model, and (with MUX2_1_REG_XCHECK_EN) a forced core fault.
module tb_mux2_1_reg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       inValid;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sel;

    logic [0:0] outW1 [3];
    logic       ovW1  [3];
    logic       mmW1  [3];
    logic [7:0] outW8 [3];
    logic       ovW8  [3];
    logic       mmW8  [3];
    logic [3:0] outW4;
    logic       ovW4;
    logic       mmW4;

    for (genvar s = 0; s < 3; s++) begin : gDuts
        mux2_1_reg #(.WIDTH(1), .STYLE(s)) uW1 (
            .clk(clk), .rst(rst), .in_valid(inValid),
            .d0(d0[0:0]), .d1(d1[0:0]), .sel(sel),
            .out(outW1[s]), .out_valid(ovW1[s]), .mismatch(mmW1[s])
        );
        mux2_1_reg #(.WIDTH(8), .STYLE(s)) uW8 (
            .clk(clk), .rst(rst), .in_valid(inValid),
            .d0(d0), .d1(d1), .sel(sel),
            .out(outW8[s]), .out_valid(ovW8[s]), .mismatch(mmW8[s])
        );
    end

    mux2_1_reg #(.WIDTH(4), .STYLE(1)) uW4 (
        .clk(clk), .rst(rst), .in_valid(inValid),
        .d0(d0[3:0]), .d1(d1[3:0]), .sel(sel),
        .out(outW4), .out_valid(ovW4), .mismatch(mmW4)
    );

    // ---------------- scoreboard ----------------
    int passCount  = 0;
    int checkCount = 0;
    logic [7:0] expQ[$];

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Apply one input set, step past the next rising edge, land 1ns after it.
    task automatic driveCycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
        inValid = v;
        d0      = a;
        d1      = b;
        sel     = s;
        @(posedge clk);
        #1;
    endtask

    task automatic checkW8(input string tag, input logic [7:0] expOut, input logic expValid);
        for (int s = 0; s < 3; s++) begin
            checkVal($sformatf("%s_out_s%0d", tag, s), outW8[s], expOut);
            checkVal($sformatf("%s_valid_s%0d", tag, s), ovW8[s], expValid);
        end
    endtask

    int expW1 [8] = '{0, 0, 0, 1, 1, 0, 1, 1};

    initial begin
        logic [7:0] idx;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;

        rst = 1'b1; inValid = 1'b0; d0 = '0; d1 = '0; sel = 1'b0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state on every instance.
        for (int s = 0; s < 3; s++) begin
            checkVal($sformatf("rst_w1_out_s%0d", s), outW1[s], 1'b0);
            checkVal($sformatf("rst_w1_valid_s%0d", s), ovW1[s], 1'b0);
        end
        checkW8("rst_w8", 8'h00, 1'b0);
        checkVal("rst_w4_mm", mmW4, 1'b0);
        rst = 1'b0;

        // 1. WIDTH=1 truth table, index = {d0,d1,sel}, one per cycle.
        for (int i = 0; i < 8; i++) expQ.push_back(8'(expW1[i]));
        for (int i = 0; i < 8; i++) begin
            idx = 8'(i);
            driveCycle(1'b1, {7'b0, idx[2]}, {7'b0, idx[1]}, idx[0]);
            ra = expQ.pop_front();
            for (int s = 0; s < 3; s++) begin
                checkVal($sformatf("tt%0d_out_s%0d", i, s), outW1[s], ra[0]);
                checkVal($sformatf("tt%0d_valid_s%0d", i, s), ovW1[s], 1'b1);
            end
        end

        // 2. WIDTH=8 select in both directions, plus single-bit edges.
        driveCycle(1'b1, 8'hA5, 8'h3C, 1'b1);
        checkW8("sel1", 8'h3C, 1'b1);
        driveCycle(1'b1, 8'hA5, 8'h3C, 1'b0);
        checkW8("sel0", 8'hA5, 1'b1);
        driveCycle(1'b1, 8'h01, 8'h80, 1'b1);
        checkW8("msb", 8'h80, 1'b1);
        driveCycle(1'b1, 8'h01, 8'h80, 1'b0);
        checkW8("lsb", 8'h01, 1'b1);

        // 3. Hold: one valid input then three idle cycles with moving data.
        driveCycle(1'b1, 8'h5A, 8'h00, 1'b0);
        checkW8("hold_load", 8'h5A, 1'b1);
        driveCycle(1'b0, 8'hFF, 8'h00, 1'b1);
        checkW8("hold1", 8'h5A, 1'b0);
        driveCycle(1'b0, 8'h12, 8'h34, 1'b0);
        checkW8("hold2", 8'h5A, 1'b0);
        driveCycle(1'b0, 8'hC3, 8'h3C, 1'b1);
        checkW8("hold3", 8'h5A, 1'b0);

        // 4. Reset mid-stream discards the pending valid input.
        driveCycle(1'b1, 8'hFF, 8'h00, 1'b0);
        checkW8("pre_rst", 8'hFF, 1'b1);
        rst = 1'b1;
        driveCycle(1'b1, 8'h00, 8'h11, 1'b1);
        rst = 1'b0;
        checkW8("mid_rst", 8'h00, 1'b0);
        for (int s = 0; s < 3; s++) checkVal($sformatf("mid_rst_mm_s%0d", s), mmW8[s], 1'b0);
        driveCycle(1'b1, 8'h00, 8'h11, 1'b1);
        checkW8("post_rst", 8'h11, 1'b1);

        // 5. WIDTH=4 traffic against the reference mux, cores must agree.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            driveCycle(1'b1, ra, rb, rs);
            checkVal($sformatf("rnd%0d_out", n), outW4, rs ? rb[3:0] : ra[3:0]);
            checkVal($sformatf("rnd%0d_mm", n), mmW4, 1'b0);
        end
        checkVal("rnd_valid", ovW4, 1'b1);

`ifdef MUX2_1_REG_XCHECK_EN
        // 6. Forced gate-core fault sets the sticky flag; only rst clears it.
        inValid = 1'b1; d0 = 8'h00; d1 = 8'h00; sel = 1'b0;
        force uW4.gateVec = 4'b0100;
        @(posedge clk); #1;
        checkVal("xc_set", mmW4, 1'b1);
        checkVal("xc_out", outW4, 4'h0);
        release uW4.gateVec;
        driveCycle(1'b1, 8'h03, 8'h0C, 1'b1);
        checkVal("xc_sticky1", mmW4, 1'b1);
        driveCycle(1'b0, 8'h00, 8'h00, 1'b0);
        checkVal("xc_sticky2", mmW4, 1'b1);
        rst = 1'b1;
        driveCycle(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b0;
        checkVal("xc_clear", mmW4, 1'b0);
`endif

        // Cross-check flags on the untouched instances stay low.
        for (int s = 0; s < 3; s++) begin
            checkVal($sformatf("end_mm_w1_s%0d", s), mmW1[s], 1'b0);
            checkVal($sformatf("end_mm_w8_s%0d", s), mmW8[s], 1'b0);
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mux2_1_reg.md
Name: mux2_1_reg

Overview:
Registered 2:1 multiplexer of parameterizable width used as the datapath select primitive. Three equivalent combinational cores are provided: behavioural (procedural case), dataflow (conditional assign) and gate-level (AND/OR/NOT per bit). Parameter STYLE selects which core drives the output. The output register adds one cycle of latency and a valid flag.

Parameters:
WIDTH, 1, data width in bits (legal 1..64).
STYLE, 0, core selection: 0 = behavioural, 1 = dataflow, 2 = gate-level; any other value builds the behavioural core.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_valid  input  1  qualifies d0/d1/sel this cycle
d0  input  WIDTH  data selected when sel=0
d1  input  WIDTH  data selected when sel=1
sel  input  1  select
out  output  WIDTH  registered mux result
out_valid  output  1  out holds a result captured from a valid input
mismatch  output  1  sticky cross-check error flag; constant 0 unless MUX2_1_REG_XCHECK_EN is defined

Behaviour:
- Combinational core, per bit i: mux_i = (d0[i] & ~sel) | (d1[i] & sel). All three cores produce identical results for 0/1 inputs.
- Behavioural core: procedural block, sel=0 -> d0, sel=1 -> d1, default -> d0.
- Dataflow core: continuous conditional assignment.
- Gate core: generated per-bit instance of mux2_1_gate_bit built from NOT, two AND and one OR primitives.
- Reset (rst=1 at a rising edge): out <= 0, out_valid <= 0, mismatch <= 0. Reset has priority over all inputs. Reset asserted mid-stream discards the pending input; the first result after release comes from the first in_valid at or after the first edge with rst=0.
- Latency: 1 cycle. When in_valid=1 at edge N, out = mux(d0,d1,sel) and out_valid=1 after edge N.
- When in_valid=0 at an edge: out holds its previous value and out_valid <= 0.
- Back-to-back valid inputs produce one result per cycle. There is no backpressure.
- No arithmetic. Widths are equal, with no extension or truncation.
- An X/Z on sel is not defined for synthesis. In simulation the behavioural core selects d0.

Optional Feature:
MUX2_1_REG_XCHECK_EN
- Defined: all three cores are instantiated regardless of STYLE.
  - Each valid cycle, the three core outputs are compared.
  - Any difference sets mismatch <= 1 at that edge. mismatch is sticky until rst.
  - STYLE still selects which core feeds out.
- Undefined: only the STYLE core is built, mismatch is tied to 0, and there is no comparison logic.

Decomposition:
- Package mux2_1_pkg holds:
  - style constants STYLE_BEH=0, STYLE_DF=1, STYLE_GATE=2;
  - MAX_WIDTH=64.
- One sub-module, mux2_1_gate_bit (ports a, b, s, y), replicated WIDTH times in the gate core.
- Behavioural and dataflow cores are inline generate branches.

Test Plan:
1. WIDTH=1, each STYLE. Drive all 8 combinations of {d0,d1,sel} (000..111) with in_valid=1, one per cycle. Expect out one cycle later to be 0,0,0,1,1,0,1,1 in that order (the 3-bit index is d0,d1,sel). out_valid=1 throughout.
2. WIDTH=8. d0=0xA5, d1=0x3C, sel=1 -> out=0x3C. Next cycle sel=0 -> out=0xA5. Each result appears one cycle after its input.
3. Hold: a valid input d0=0x5A, sel=0, then in_valid=0 for 3 cycles with changing d0/d1/sel. Expect out stays 0x5A and out_valid=0 for those 3 cycles.
4. Reset: after out=0xFF, assert rst for 1 cycle while in_valid=1, d1=0x11, sel=1. Expect out=0, out_valid=0, mismatch=0 after that edge. The next valid input then propagates normally.
5. With MUX2_1_REG_XCHECK_EN, WIDTH=4, random valid traffic for 1000 cycles. Expect mismatch=0 throughout.
6. With MUX2_1_REG_XCHECK_EN, force gate-core bit 2 to 1 during a valid input d0=d1=0x0. Expect mismatch=1 next edge, staying 1 after the force is released, cleared only by rst.
